// File: rtl/ram_write_arbiter.sv
`default_nettype none
// ram_write_arbiter: shares the RAM write port between two clients. Client 0 has priority,
// client 1 gets a starvation-limited turn, and a watchdog aborts transactions that never finish.
module ram_write_arbiter #(
   parameter int MAX_CONSECUTIVE = 4,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_request_0,
   input  logic [22:0] wr_address_0,
   input  logic [31:0] wr_data_0,
   input  logic [3:0]  wr_mask_0,
   input  logic [8:0]  wr_burst_length_0,
   output logic        wr_done_0,
   input  logic        wr_request_1,
   input  logic [22:0] wr_address_1,
   input  logic [31:0] wr_data_1,
   input  logic [3:0]  wr_mask_1,
   input  logic [8:0]  wr_burst_length_1,
   output logic        wr_done_1,
   output logic        wr_request,
   output logic [22:0] wr_address,
   output logic [31:0] wr_data,
   output logic [3:0]  wr_mask,
   output logic [8:0]  wr_burst_length,
   input  logic        wr_done,
   output logic        owner,
   output logic        timeout_error
);
   localparam int CNT_W = 4;
   localparam int WD_W  = 16;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CONSECUTIVE);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic             owner_next;
   logic [CNT_W-1:0] consec, consec_next;
   logic [WD_W-1:0]  watchdog, watchdog_next;
   logic             timeout_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         owner         <= 1'b0;
         consec        <= '0;
         watchdog      <= '0;
         timeout_error <= 1'b0;
      end else begin
         state         <= state_next;
         owner         <= owner_next;
         consec        <= consec_next;
         watchdog      <= watchdog_next;
         timeout_error <= timeout_next;
      end
   end

   always_comb begin
      state_next    = state;
      owner_next    = owner;
      consec_next   = consec;
      watchdog_next = watchdog;
      timeout_next  = timeout_error;
      wr_request    = 1'b0;
      wr_done_0     = 1'b0;
      wr_done_1     = 1'b0;
      case (state)
         IDLE: begin
            watchdog_next = '0;
            if (wr_request_0 || wr_request_1) begin
               state_next = GRANT;
               // Client 0 wins unless client 1 has waited through MAX_CONSECUTIVE grants.
               if (wr_request_0 && !(wr_request_1 && consec == MAX_CNT)) begin
                  owner_next = 1'b0;
                  if (!wr_request_1)
                     consec_next = '0;
                  else if (consec != MAX_CNT)
                     consec_next = consec + CNT_W'(1);
               end else begin
                  owner_next  = 1'b1;
                  consec_next = '0;
               end
            end
         end
         GRANT: begin
            wr_request    = 1'b1;
            watchdog_next = watchdog + WD_W'(1);
            if (wr_done || watchdog == WD_LIMIT) begin
               wr_done_0  = ~owner;
               wr_done_1  = owner;
               state_next = RELEASE;
               if (!wr_done)
                  timeout_next = 1'b1;
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Fields follow the owner combinationally so burst data can change every beat.
   assign wr_address      = owner ? wr_address_1      : wr_address_0;
   assign wr_data         = owner ? wr_data_1         : wr_data_0;
   assign wr_mask         = owner ? wr_mask_1         : wr_mask_0;
   assign wr_burst_length = owner ? wr_burst_length_1 : wr_burst_length_0;

endmodule
`default_nettype wire

// File: tb/tb_ram_write_arbiter.sv
`default_nettype none
// tb_ram_write_arbiter: randomized clients and RAM responder checked every cycle against
// a transaction-level model of the arbitration, watchdog and handshake rules.
module tb_ram_write_arbiter;
   localparam int MAX_CONSECUTIVE = 4;
   localparam int TIMEOUT_CYCLES  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req  [2];
   logic [22:0] addr [2];
   logic [31:0] data [2];
   logic [3:0]  mask [2];
   logic [8:0]  blen [2];
   logic        ram_done;
   logic        wr_done_0, wr_done_1, wr_request, owner, timeout_error;
   logic [22:0] wr_address;
   logic [31:0] wr_data;
   logic [3:0]  wr_mask;
   logic [8:0]  wr_burst_length;

   always #5 clk = ~clk;

   ram_write_arbiter #(
      .MAX_CONSECUTIVE(MAX_CONSECUTIVE),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_request_0(req[0]), .wr_address_0(addr[0]), .wr_data_0(data[0]),
      .wr_mask_0(mask[0]), .wr_burst_length_0(blen[0]), .wr_done_0(wr_done_0),
      .wr_request_1(req[1]), .wr_address_1(addr[1]), .wr_data_1(data[1]),
      .wr_mask_1(mask[1]), .wr_burst_length_1(blen[1]), .wr_done_1(wr_done_1),
      .wr_request(wr_request), .wr_address(wr_address), .wr_data(wr_data),
      .wr_mask(wr_mask), .wr_burst_length(wr_burst_length), .wr_done(ram_done),
      .owner(owner), .timeout_error(timeout_error)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Stimulus controls: enabled clients, request probability, idle gap, RAM behaviour.
   bit en [2];
   int req_pct  = 50;
   int max_wait = 3;
   int ram_mode = 1;   // 0 random incl. never, 1 fixed 4, 2 never, 3 random 0..6
   int wait_cnt [2];
   bit saw_done [2];
   int ram_age  = -1;
   int ram_delay = 0;

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            wait_cnt[i] = 0;
         end
         ram_done = 1'b0;
         ram_age  = -1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
               if (saw_done[i]) begin
                  req[i] = 1'b0;
                  wait_cnt[i] = $urandom_range(max_wait, 0);
               end else begin
                  data[i] = $urandom;
               end
            end else if (wait_cnt[i] > 0) begin
               wait_cnt[i]--;
            end else if (en[i] && $urandom_range(99, 0) < req_pct) begin
               req[i]  = 1'b1;
               addr[i] = 23'($urandom);
               data[i] = $urandom;
               mask[i] = 4'($urandom);
               blen[i] = 9'($urandom_range(8, 1));
            end
         end
         if (wr_request) begin
            if (ram_age < 0) begin
               ram_age = 0;
               case (ram_mode)
                  0:       ram_delay = ($urandom_range(5, 0) == 0) ? 1000 : $urandom_range(6, 0);
                  1:       ram_delay = 4;
                  2:       ram_delay = 1000;
                  default: ram_delay = $urandom_range(6, 0);
               endcase
            end else begin
               ram_age++;
            end
            ram_done = (ram_age == ram_delay);
         end else begin
            ram_age  = -1;
            ram_done = ($urandom_range(7, 0) == 0);
         end
      end
   end

   // Reference model: a transaction is either running, in its one-cycle release, or the
   // port is free and arbitrates. Starvation is judged from the grant history.
   bit m_active, m_cool, m_owner, m_err;
   int m_age;
   bit hist [$];   // per grant: 1 if client 0 was granted while client 1 waited

   function automatic int trailing_run();
      int r = 0;
      for (int k = hist.size() - 1; k >= 0 && hist[k]; k--) r++;
      return r;
   endfunction

   task automatic model_step();
      bit fin, g;
      bit exp_d [2];
      exp_d[0] = 1'b0;
      exp_d[1] = 1'b0;
      check_eq("owner", owner, m_owner);
      check_eq("timeout_error", timeout_error, m_err);
      check_eq("wr_request", wr_request, m_active);
      if (m_active) begin
         check_eq("wr_address", wr_address, addr[m_owner]);
         check_eq("wr_data", wr_data, data[m_owner]);
         check_eq("wr_mask", wr_mask, mask[m_owner]);
         check_eq("wr_burst_length", wr_burst_length, blen[m_owner]);
         fin = ram_done || (m_age == TIMEOUT_CYCLES - 1);
         if (fin) exp_d[m_owner] = 1'b1;
         if (fin) begin
            if (!ram_done) m_err = 1'b1;
            m_active = 1'b0;
            m_cool   = 1'b1;
         end else begin
            m_age++;
         end
      end else if (m_cool) begin
         m_cool = 1'b0;
      end else if (req[0] || req[1]) begin
         g = (req[0] && !(req[1] && trailing_run() >= MAX_CONSECUTIVE)) ? 1'b0 : 1'b1;
         hist.push_back(!g && req[1]);
         m_owner  = g;
         m_active = 1'b1;
         m_age    = 0;
      end
      check_eq("wr_done_0", wr_done_0, exp_d[0]);
      check_eq("wr_done_1", wr_done_1, exp_d[1]);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_cool   = 1'b0;
         m_owner  = 1'b0;
         m_err    = 1'b0;
         m_age    = 0;
         hist.delete();
      end else begin
         model_step();
      end
      saw_done[0] = wr_done_0;
      saw_done[1] = wr_done_1;
   end

   task automatic run_phase(input bit e0, input bit e1, input int pct, input int mw,
                            input int rm, input int cycles);
      en[0] = e0; en[1] = e1; req_pct = pct; max_wait = mw; ram_mode = rm;
      repeat (cycles) @(posedge clk);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; addr[i] = '0; data[i] = '0; mask[i] = '0; blen[i] = '0;
         en[i] = 1'b0; wait_cnt[i] = 0; saw_done[i] = 1'b0;
      end
      ram_done = 1'b0;
      #2;
      check_eq("reset_wr_request", wr_request, 1'b0);
      check_eq("reset_wr_done_0", wr_done_0, 1'b0);
      check_eq("reset_wr_done_1", wr_done_1, 1'b0);
      check_eq("reset_owner", owner, 1'b0);
      check_eq("reset_timeout_error", timeout_error, 1'b0);
      @(posedge clk); #3; rst_n = 1'b1;

      run_phase(1, 0, 50, 3, 1, 200);    // client 0 alone, fixed RAM latency
      run_phase(1, 1, 100, 0, 3, 400);   // both requesting back-to-back
      run_phase(0, 1, 100, 0, 3, 200);   // client 1 alone
      run_phase(1, 0, 100, 0, 2, 100);   // RAM never completes: watchdog aborts
      run_phase(1, 0, 100, 0, 1, 60);    // requests still served afterwards

      // Asynchronous reset while a burst is in flight.
      en[0] = 1'b1; en[1] = 1'b1; ram_mode = 2;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         found = wr_request;
      end
      check_eq("grant_before_reset", found, 1'b1);
      @(posedge clk); #3;
      check_eq("wr_request_before_reset", wr_request, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_wr_request", wr_request, 1'b0);
      check_eq("async_reset_owner", owner, 1'b0);
      check_eq("async_reset_timeout_error", timeout_error, 1'b0);
      @(posedge clk); #3; rst_n = 1'b1;

      run_phase(1, 1, 100, 0, 3, 200);
      run_phase(1, 1, 40, 3, 0, 2500);   // mixed traffic with timeouts and stray wr_done
      en[0] = 1'b0; en[1] = 1'b0;
      repeat (60) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
